// File: rtl/conv_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : conv_encoder
//  Brief    : 802.11a K=7 convolutional encoder (g0=133o, g1=171o) with
//             rate 1/2 and 3/4 puncturing selected by the RATE code on
//             tuser. AXI4-Stream in/out, one output beat per input beat,
//             single output register stage.
//  Option   : define ENCODER_TWO_THIRDS_EN to build rate 2/3 puncturing
//             for RATE 4'b0001 (48 Mb/s); otherwise that code runs at 1/2.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_encoder #(
    parameter int WIDTH = 24            // input bits per beat, multiple of 6
) (
    input  logic                 aclk,
    input  logic                 aresetn,  // synchronous, active-high
    input  logic [WIDTH-1:0]     s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [3:0]           s_axis_tuser,
    input  logic                 s_axis_tlast,
    output logic [2*WIDTH-1:0]   m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [3:0]           m_axis_tuser,
    output logic                 m_axis_tlast
);

    // RATE codes (802.11a SIGNAL field R1..R4)
    localparam logic [3:0] c_rate_6m  = 4'b1101;
    localparam logic [3:0] c_rate_9m  = 4'b1111;
    localparam logic [3:0] c_rate_12m = 4'b0101;
    localparam logic [3:0] c_rate_18m = 4'b0111;
    localparam logic [3:0] c_rate_24m = 4'b1001;
    localparam logic [3:0] c_rate_36m = 4'b1011;
    localparam logic [3:0] c_rate_54m = 4'b0011;

    // Puncturing selection
    localparam logic [1:0] c_sel_half  = 2'd0;
    localparam logic [1:0] c_sel_3q    = 2'd1;
`ifdef ENCODER_TWO_THIRDS_EN
    localparam logic [3:0] c_rate_48m  = 4'b0001;
    localparam logic [1:0] c_sel_2t    = 2'd2;
`endif

    // Encoder history: r_sr[0] is the most recent bit (x1), r_sr[5] is x6
    logic [5:0]           r_sr;
    logic [2*WIDTH-1:0]   r_tdata;
    logic [3:0]           r_tuser;
    logic                 r_tlast;
    logic                 r_tvalid;

    logic                 w_accept;
    logic [1:0]           w_rate_sel;
    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic [5:0]           w_hist;
    logic [2*WIDTH-1:0]   w_half;
    logic [2*WIDTH-1:0]   w_three_q;
`ifdef ENCODER_TWO_THIRDS_EN
    logic [2*WIDTH-1:0]   w_two_t;
`endif
    logic [2*WIDTH-1:0]   w_coded;

    // Single register stage: accept whenever the output slot is free or draining
    assign s_axis_tready = !r_tvalid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;

    // Decode the RATE code into a puncturing pattern; unknown codes use 1/2
    always_comb begin
        w_rate_sel = c_sel_half;
        case (s_axis_tuser)
            c_rate_6m, c_rate_12m, c_rate_24m:            w_rate_sel = c_sel_half;
            c_rate_9m, c_rate_18m, c_rate_36m, c_rate_54m: w_rate_sel = c_sel_3q;
`ifdef ENCODER_TWO_THIRDS_EN
            c_rate_48m:                                    w_rate_sel = c_sel_2t;
`endif
            default:                                       w_rate_sel = c_sel_half;
        endcase
    end

    // Run the shift register across all WIDTH bits, LSB first in time
    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_hist = r_sr;
        for (int k = 0; k < WIDTH; k++) begin
            // A = x0^x2^x3^x5^x6, B = x0^x1^x2^x3^x6
            w_a[k] = s_axis_tdata[k] ^ w_hist[1] ^ w_hist[2] ^ w_hist[4] ^ w_hist[5];
            w_b[k] = s_axis_tdata[k] ^ w_hist[0] ^ w_hist[1] ^ w_hist[2] ^ w_hist[5];
            w_hist = {w_hist[4:0], s_axis_tdata[k]};
        end
    end

    // Build each punctured layout, LSB-aligned, unused upper bits zero
    always_comb begin
        w_half    = '0;
        w_three_q = '0;
        for (int k = 0; k < WIDTH; k++) begin
            w_half[2*k]   = w_a[k];
            w_half[2*k+1] = w_b[k];
        end
        // Per triple keep A0,B0,A1,B2 (B1 and A2 are stolen)
        for (int j = 0; j < WIDTH/3; j++) begin
            w_three_q[4*j]   = w_a[3*j];
            w_three_q[4*j+1] = w_b[3*j];
            w_three_q[4*j+2] = w_a[3*j+1];
            w_three_q[4*j+3] = w_b[3*j+2];
        end
`ifdef ENCODER_TWO_THIRDS_EN
        // Per pair keep A0,B0,A1 (B1 is stolen)
        w_two_t = '0;
        for (int j = 0; j < WIDTH/2; j++) begin
            w_two_t[3*j]   = w_a[2*j];
            w_two_t[3*j+1] = w_b[2*j];
            w_two_t[3*j+2] = w_a[2*j+1];
        end
`endif
    end

    // Select the layout for this beat's rate
    always_comb begin
        w_coded = w_half;
        case (w_rate_sel)
            c_sel_3q: w_coded = w_three_q;
`ifdef ENCODER_TWO_THIRDS_EN
            c_sel_2t: w_coded = w_two_t;
`endif
            default:  w_coded = w_half;
        endcase
    end

    // Output register and encoder state; reset drops any pending beat
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            r_sr     <= '0;
            r_tdata  <= '0;
            r_tuser  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else if (w_accept) begin
            r_sr     <= w_hist;
            r_tdata  <= w_coded;
            r_tuser  <= s_axis_tuser;
            r_tlast  <= s_axis_tlast;
            r_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tvalid = r_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_conv_encoder
//  Brief    : Directed self-checking bench for conv_encoder (WIDTH=24).
//             Hand-derived vectors plus a serial generator-mask model for
//             the multi-beat 3/4 run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_encoder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [23:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [3:0]  s_tuser;
    logic        s_tlast;
    logic [47:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [3:0]  m_tuser;
    logic        m_tlast;

    int          n_vec = 0;
    int          n_err = 0;
    logic [5:0]  mdl_state;
    logic [47:0] exp_v;

    // 100 MHz clock
    always #5 aclk = ~aclk;

    conv_encoder #(.WIDTH(24)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast)
    );

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Serial reference: window bit 6 = current bit, bit 0 = oldest, masks 133o/171o
    function automatic logic [47:0] model(input logic [23:0] d, input logic [3:0] u,
                                          input logic [5:0] st, output logic [5:0] st_out);
        logic [5:0]  h;
        logic [6:0]  win;
        logic        a, b, keep_a, keep_b;
        int          mode, p;
        logic [47:0] r;
        case (u)
            4'b1111, 4'b0111, 4'b1011, 4'b0011: mode = 1;
`ifdef ENCODER_TWO_THIRDS_EN
            4'b0001:                            mode = 2;
`endif
            default:                            mode = 0;
        endcase
        h = st; p = 0; r = '0;
        for (int k = 0; k < 24; k++) begin
            win = {d[k], h};
            a = ^(win & 7'o133);
            b = ^(win & 7'o171);
            keep_a = 1'b1; keep_b = 1'b1;
            if (mode == 1) begin
                if (k % 3 == 2) keep_a = 1'b0;
                if (k % 3 == 1) keep_b = 1'b0;
            end else if (mode == 2) begin
                if (k % 2 == 1) keep_b = 1'b0;
            end
            if (keep_a) begin r[p] = a; p++; end
            if (keep_b) begin r[p] = b; p++; end
            h = {d[k], h[5:1]};
        end
        st_out = h;
        return r;
    endfunction

    task automatic do_reset();
        aresetn = 1'b1;
        s_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b0;
        mdl_state = '0;
    endtask

    // Present one beat and hold it until the DUT takes it (bounded wait)
    task automatic push(input logic [23:0] d, input logic [3:0] u, input logic l,
                        output logic [47:0] exp);
        logic [5:0] nxt;
        int n;
        exp = model(d, u, mdl_state, nxt);
        mdl_state = nxt;
        s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        #1;
        n = 0;
        while (!s_tready && n < 20) begin
            @(negedge aclk); #1; n++;
        end
        if (n >= 20) check_eq("accept_timeout", 48'(s_tready), 48'd1);
        @(posedge aclk);
        #1 s_tvalid = 1'b0;
    endtask

    logic [23:0] run_d [10] = '{24'h5a3c96, 24'hffffff, 24'h000000, 24'h123456, 24'habcdef,
                                24'h800001, 24'h0f0f0f, 24'h7e7e7e, 24'hc00003, 24'h2468ac};
    logic [3:0]  run_u [4]  = '{4'b1111, 4'b0111, 4'b1011, 4'b0011};

    initial begin
        aresetn = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tuser = '0; s_tlast = 1'b0;
        m_tready = 1'b1; mdl_state = '0;

        // Reset state
        do_reset();
        @(negedge aclk);
        check_eq("rst_tvalid", 48'(m_tvalid), 48'd0);
        check_eq("rst_tdata",  m_tdata,       48'd0);
        check_eq("rst_tuser",  48'(m_tuser),  48'd0);
        check_eq("rst_tlast",  48'(m_tlast),  48'd0);
        check_eq("rst_tready", 48'(s_tready), 48'd1);

        // Rate 1/2 reference vector
        push(24'h000c8d, 4'b1101, 1'b1, exp_v);
        @(negedge aclk);
        check_eq("half_c8d",      m_tdata,       48'h000e7c40858b);
        check_eq("half_c8d_vld",  48'(m_tvalid), 48'd1);
        check_eq("half_c8d_last", 48'(m_tlast),  48'd1);
        check_eq("half_c8d_user", 48'(m_tuser),  48'hd);

        // Impulse response at rate 1/2
        do_reset();
        push(24'h000001, 4'b1101, 1'b0, exp_v);
        @(negedge aclk);
        check_eq("half_impulse", m_tdata, 48'h0000000034fb);

        // State carried across a beat boundary, back-to-back beats
        do_reset();
        push(24'h800000, 4'b1101, 1'b0, exp_v);
        @(negedge aclk);
        check_eq("carry_beat0", m_tdata, 48'hc00000000000);
        push(24'h000000, 4'b1101, 1'b0, exp_v);
        @(negedge aclk);
        check_eq("carry_beat1", m_tdata, 48'h000000000d3e);

        // Rate 3/4 impulse, upper 16 bits unused
        do_reset();
        push(24'h000001, 4'b1111, 1'b0, exp_v);
        @(negedge aclk);
        check_eq("q34_impulse", m_tdata,               48'h00000000033b);
        check_eq("q34_upper",   48'(m_tdata[47:32]),   48'd0);

        // Unknown RATE code falls back to 1/2
        do_reset();
        push(24'h000001, 4'b0000, 1'b0, exp_v);
        @(negedge aclk);
        check_eq("unknown_rate", m_tdata, 48'h0000000034fb);

        // 48M code: 2/3 when built in, else 1/2
        do_reset();
        push(24'h000001, 4'b0001, 1'b0, exp_v);
        @(negedge aclk);
`ifdef ENCODER_TWO_THIRDS_EN
        check_eq("rate_48m", m_tdata, 48'h00000000073b);
`else
        check_eq("rate_48m", m_tdata, 48'h0000000034fb);
`endif

        // Ten consecutive 3/4 beats with tlast, state continuous
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push(run_d[i], run_u[i % 4], 1'b1, exp_v);
            @(negedge aclk);
            check_eq($sformatf("run34_data%0d", i), m_tdata, exp_v);
            check_eq($sformatf("run34_user%0d", i), 48'(m_tuser), 48'(run_u[i % 4]));
            check_eq($sformatf("run34_last%0d", i), 48'(m_tlast), 48'd1);
        end

        // Backpressure: pending beat holds, then drain+accept in one cycle
        do_reset();
        m_tready = 1'b0;
        push(24'h000001, 4'b1101, 1'b0, exp_v);
        @(negedge aclk);
        check_eq("bp_first", m_tdata, 48'h0000000034fb);
        s_tdata = 24'h000001; s_tuser = 4'b1111; s_tlast = 1'b1; s_tvalid = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk); #1;
        check_eq("bp_tready_low", 48'(s_tready), 48'd0);
        check_eq("bp_hold_data",  m_tdata,       48'h0000000034fb);
        check_eq("bp_hold_vld",   48'(m_tvalid), 48'd1);
        check_eq("bp_hold_last",  48'(m_tlast),  48'd0);
        m_tready = 1'b1;
        #1;
        check_eq("bp_tready_high", 48'(s_tready), 48'd1);
        @(posedge aclk);
        #1 s_tvalid = 1'b0;
        @(negedge aclk);
        check_eq("bp_second_data", m_tdata,       48'h00000000033b);
        check_eq("bp_second_user", 48'(m_tuser),  48'hf);
        check_eq("bp_second_last", 48'(m_tlast),  48'd1);
        check_eq("bp_second_vld",  48'(m_tvalid), 48'd1);
        @(negedge aclk);
        check_eq("bp_drained", 48'(m_tvalid), 48'd0);

        // Reset with a pending beat discards it and clears the history
        do_reset();
        m_tready = 1'b0;
        push(24'h800000, 4'b1101, 1'b0, exp_v);
        @(negedge aclk);
        check_eq("mid_pending", 48'(m_tvalid), 48'd1);
        aresetn = 1'b1;
        @(posedge aclk);
        #1 aresetn = 1'b0;
        mdl_state = '0;
        @(negedge aclk);
        check_eq("mid_rst_vld",  48'(m_tvalid), 48'd0);
        check_eq("mid_rst_data", m_tdata,       48'd0);
        m_tready = 1'b1;
        push(24'h000001, 4'b1101, 1'b0, exp_v);
        @(negedge aclk);
        check_eq("mid_after", m_tdata, 48'h0000000034fb);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case a wait is ever left unbounded
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
